// File: rtl/bus_sequencer.sv
// Hardwired fetch/decode/indirect sequencer driving the internal bus select and register strobes.
// Optional single-step PAUSE state is compiled in when BUS_SEQ_STEP_EN is defined.
module bus_sequencer #(
    parameter int EXEC_TIMEOUT = 16,
    parameter int SC_W         = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BUS_SEQ_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    input  logic            run,
    input  logic            halt,
    input  logic [15:0]     ir,
    input  logic            mem_wait,
    input  logic            exec_done,
    output logic [2:0]      bus_sel,
    output logic            ld_ar,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            mem_rd,
    output logic            exec_start,
    output logic [2:0]      opcode,
    output logic            ind,
    output logic [SC_W-1:0] sc,
    output logic            busy,
    output logic            fault
);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_I, DECODE, INDIRECT, EXEC, HALTED, PAUSE
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;
    localparam logic [7:0] TIMEOUT  = 8'(EXEC_TIMEOUT);

    state_t          state_reg;
    logic [2:0]      bus_sel_reg;
    logic            ld_ar_reg, ld_ir_reg, inc_pc_reg, mem_rd_reg, exec_start_reg;
    logic [2:0]      opcode_reg;
    logic            ind_reg, busy_reg, fault_reg;
    logic [SC_W-1:0] sc_reg, sc_next;
    logic [7:0]      exec_cnt_reg;
    logic            unused_ir_bits;

    assign sc_next        = (sc_reg == '1) ? sc_reg : sc_reg + 1'b1;
    assign unused_ir_bits = ^ir[11:0];

    // Strobes are registered for the cycle being entered; memory readiness is sampled
    // at the edge that starts each read cycle, so a ready read cycle leaves on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bus_sel_reg    <= BUS_NONE;
            ld_ar_reg      <= 1'b0;
            ld_ir_reg      <= 1'b0;
            inc_pc_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            exec_start_reg <= 1'b0;
            opcode_reg     <= 3'd0;
            ind_reg        <= 1'b0;
            sc_reg         <= '0;
            busy_reg       <= 1'b0;
            fault_reg      <= 1'b0;
            exec_cnt_reg   <= 8'd0;
        end else begin
            bus_sel_reg    <= BUS_NONE;
            ld_ar_reg      <= 1'b0;
            ld_ir_reg      <= 1'b0;
            inc_pc_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            exec_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sc_reg <= '0;
                    if (run) begin
                        state_reg   <= FETCH_A;
                        bus_sel_reg <= BUS_PC;
                        ld_ar_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                    end else begin
                        busy_reg    <= 1'b0;
                    end
                end
                FETCH_A: begin
                    state_reg   <= FETCH_I;
                    bus_sel_reg <= BUS_MEM;
                    mem_rd_reg  <= 1'b1;
                    ld_ir_reg   <= !mem_wait;
                    inc_pc_reg  <= !mem_wait;
                    sc_reg      <= sc_next;
                end
                FETCH_I: begin
                    if (ld_ir_reg) begin
                        state_reg   <= DECODE;
                        bus_sel_reg <= BUS_IR;
                        ld_ar_reg   <= 1'b1;
                        sc_reg      <= sc_next;
                    end else begin
                        bus_sel_reg <= BUS_MEM;
                        mem_rd_reg  <= 1'b1;
                        ld_ir_reg   <= !mem_wait;
                        inc_pc_reg  <= !mem_wait;
                    end
                end
                DECODE: begin
                    opcode_reg <= ir[14:12];
                    ind_reg    <= ir[15];
                    sc_reg     <= sc_next;
                    if (ir[15] && ir[14:12] != 3'd7) begin
                        state_reg   <= INDIRECT;
                        bus_sel_reg <= BUS_MEM;
                        mem_rd_reg  <= 1'b1;
                        ld_ar_reg   <= !mem_wait;
                    end else begin
                        state_reg      <= EXEC;
                        exec_start_reg <= 1'b1;
                        exec_cnt_reg   <= 8'd1;
                    end
                end
                INDIRECT: begin
                    if (ld_ar_reg) begin
                        state_reg      <= EXEC;
                        exec_start_reg <= 1'b1;
                        exec_cnt_reg   <= 8'd1;
                        sc_reg         <= sc_next;
                    end else begin
                        bus_sel_reg <= BUS_MEM;
                        mem_rd_reg  <= 1'b1;
                        ld_ar_reg   <= !mem_wait;
                    end
                end
                EXEC: begin
                    // exec_done on the final allowed cycle still wins over the timeout
                    if (exec_done) begin
                        sc_reg <= '0;
                        if (halt) begin
                            state_reg <= HALTED;
                            busy_reg  <= 1'b0;
                        end
`ifdef BUS_SEQ_STEP_EN
                        else if (step_mode) begin
                            state_reg <= PAUSE;
                        end
`endif
                        else if (run) begin
                            state_reg   <= FETCH_A;
                            bus_sel_reg <= BUS_PC;
                            ld_ar_reg   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else if (exec_cnt_reg >= TIMEOUT) begin
                        state_reg <= HALTED;
                        fault_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        sc_reg    <= '0;
                    end else begin
                        exec_cnt_reg <= exec_cnt_reg + 8'd1;
                        sc_reg       <= sc_next;
                    end
                end
                HALTED: begin
                    sc_reg   <= '0;
                    busy_reg <= 1'b0;
                end
`ifdef BUS_SEQ_STEP_EN
                PAUSE: begin
                    sc_reg <= '0;
                    if (halt) begin
                        state_reg <= HALTED;
                        busy_reg  <= 1'b0;
                    end else if (step) begin
                        state_reg   <= FETCH_A;
                        bus_sel_reg <= BUS_PC;
                        ld_ar_reg   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    sc_reg    <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_sel    = bus_sel_reg;
    assign ld_ar      = ld_ar_reg;
    assign ld_ir      = ld_ir_reg;
    assign inc_pc     = inc_pc_reg;
    assign mem_rd     = mem_rd_reg;
    assign exec_start = exec_start_reg;
    assign opcode     = opcode_reg;
    assign ind        = ind_reg;
    assign sc         = sc_reg;
    assign busy       = busy_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer (default build): fetch/decode/indirect sequencing,
// memory stalls, exec timeout, halt at boundary and reset mid-read.
module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, halt, mem_wait, exec_done;
    logic [15:0] ir;
    logic [2:0]  bus_sel, opcode;
    logic        ld_ar, ld_ir, inc_pc, mem_rd, exec_start, ind, busy, fault;
    logic [3:0]  sc;
    int          n_cmp = 0;
    int          n_err = 0;

    bus_sequencer #(.EXEC_TIMEOUT(16), .SC_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .ir(ir),
        .mem_wait(mem_wait), .exec_done(exec_done),
        .bus_sel(bus_sel), .ld_ar(ld_ar), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .mem_rd(mem_rd), .exec_start(exec_start), .opcode(opcode), .ind(ind),
        .sc(sc), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bus_sel, ld_ar, ld_ir, inc_pc, mem_rd, exec_start, sc, busy in one step
    task automatic check_outs(input string tag, input logic [2:0] b, input logic la,
                              input logic li, input logic ip, input logic mr,
                              input logic es, input logic [3:0] s, input logic bz);
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'(b));
        check({tag, ".ld_ar"}, 32'(ld_ar), 32'(la));
        check({tag, ".ld_ir"}, 32'(ld_ir), 32'(li));
        check({tag, ".inc_pc"}, 32'(inc_pc), 32'(ip));
        check({tag, ".mem_rd"}, 32'(mem_rd), 32'(mr));
        check({tag, ".exec_start"}, 32'(exec_start), 32'(es));
        check({tag, ".sc"}, 32'(sc), 32'(s));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt = 1'b0; mem_wait = 1'b0; exec_done = 1'b1; ir = 16'h0000;
        tick();
        tick();
        check_outs("reset", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        check("reset.opcode", 32'(opcode), 0);
        check("reset.ind", 32'(ind), 0);
        check("reset.fault", 32'(fault), 0);

        // Instruction 1: direct, opcode 2, exec_done in third EXEC cycle
        rst = 1'b0; exec_done = 1'b0; run = 1'b1; ir = 16'h2005;
        tick(); check_outs("i1.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);
        tick(); check_outs("i1.T1", 3'd7, 0, 1, 1, 1, 0, 4'd1, 1);
        tick(); check_outs("i1.T2", 3'd5, 1, 0, 0, 0, 0, 4'd2, 1);
        tick(); check_outs("i1.E1", 3'd0, 0, 0, 0, 0, 1, 4'd3, 1);
        check("i1.opcode", 32'(opcode), 2);
        check("i1.ind", 32'(ind), 0);
        tick(); check_outs("i1.E2", 3'd0, 0, 0, 0, 0, 0, 4'd4, 1);
        tick(); check_outs("i1.E3", 3'd0, 0, 0, 0, 0, 0, 4'd5, 1);
        exec_done = 1'b1;
        ir = 16'h9123;
        tick(); check_outs("i2.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);

        // Instruction 2: indirect, opcode 1
        exec_done = 1'b0;
        tick(); check_outs("i2.T1", 3'd7, 0, 1, 1, 1, 0, 4'd1, 1);
        tick(); check_outs("i2.T2", 3'd5, 1, 0, 0, 0, 0, 4'd2, 1);
        tick(); check_outs("i2.T3", 3'd7, 1, 0, 0, 1, 0, 4'd3, 1);
        check("i2.opcode", 32'(opcode), 1);
        check("i2.ind", 32'(ind), 1);
        tick(); check_outs("i2.E1", 3'd0, 0, 0, 0, 0, 1, 4'd4, 1);
        exec_done = 1'b1;
        ir = 16'hF800;
        tick(); check_outs("i3.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);

        // Instruction 3: opcode 7 with I=1 skips INDIRECT
        exec_done = 1'b0;
        tick(); check_outs("i3.T1", 3'd7, 0, 1, 1, 1, 0, 4'd1, 1);
        tick(); check_outs("i3.T2", 3'd5, 1, 0, 0, 0, 0, 4'd2, 1);
        tick(); check_outs("i3.E1", 3'd0, 0, 0, 0, 0, 1, 4'd3, 1);
        check("i3.opcode", 32'(opcode), 7);
        check("i3.ind", 32'(ind), 1);
        exec_done = 1'b1;
        ir = 16'h2005;
        tick(); check_outs("i4.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);

        // Instruction 4: three stalled FETCH_I cycles, then exec timeout
        exec_done = 1'b0; mem_wait = 1'b1;
        tick(); check_outs("i4.stall1", 3'd7, 0, 0, 0, 1, 0, 4'd1, 1);
        tick(); check_outs("i4.stall2", 3'd7, 0, 0, 0, 1, 0, 4'd1, 1);
        tick(); check_outs("i4.stall3", 3'd7, 0, 0, 0, 1, 0, 4'd1, 1);
        mem_wait = 1'b0;
        tick(); check_outs("i4.ready", 3'd7, 0, 1, 1, 1, 0, 4'd1, 1);
        tick(); check_outs("i4.T2", 3'd5, 1, 0, 0, 0, 0, 4'd2, 1);
        tick(); check_outs("i4.E1", 3'd0, 0, 0, 0, 0, 1, 4'd3, 1);
        for (int i = 2; i <= 16; i++) begin
            run = i[0];
            tick();
            check($sformatf("i4.E%0d.busy", i), 32'(busy), 1);
            check($sformatf("i4.E%0d.fault", i), 32'(fault), 0);
            check($sformatf("i4.E%0d.sc", i), 32'(sc), (i + 2 > 15) ? 15 : i + 2);
        end
        tick();
        check_outs("i4.halted", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        check("i4.fault", 32'(fault), 1);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            tick();
            check($sformatf("i4.hold%0d.bus_sel", i), 32'(bus_sel), 0);
            check($sformatf("i4.hold%0d.fault", i), 32'(fault), 1);
            check($sformatf("i4.hold%0d.busy", i), 32'(busy), 0);
        end
        rst = 1'b1;
        tick();
        check("i4.rst.fault", 32'(fault), 0);

        // Instruction 5: halt raised during DECODE stops at the boundary
        rst = 1'b0; run = 1'b1;
        tick(); check_outs("i5.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);
        tick();
        tick(); check_outs("i5.T2", 3'd5, 1, 0, 0, 0, 0, 4'd2, 1);
        halt = 1'b1;
        tick(); check_outs("i5.E1", 3'd0, 0, 0, 0, 0, 1, 4'd3, 1);
        tick(); check("i5.E2.busy", 32'(busy), 1);
        exec_done = 1'b1;
        tick(); check_outs("i5.halted", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        check("i5.fault", 32'(fault), 0);
        halt = 1'b0; exec_done = 1'b0;
        tick(); check_outs("i5.stay1", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        tick(); check_outs("i5.stay2", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);

        // Instruction 6: run dropped mid-instruction completes, then IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); check_outs("i6.T0", 3'd2, 1, 0, 0, 0, 0, 4'd0, 1);
        run = 1'b0;
        tick();
        tick();
        tick(); check_outs("i6.E1", 3'd0, 0, 0, 0, 0, 1, 4'd3, 1);
        exec_done = 1'b1;
        tick(); check_outs("i6.idle", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        exec_done = 1'b0;
        tick(); check_outs("i6.idle2", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);

        // Instruction 7: reset while INDIRECT is stalled
        run = 1'b1; ir = 16'h9123;
        tick();
        tick();
        tick();
        mem_wait = 1'b1;
        tick(); check_outs("i7.T3", 3'd7, 0, 0, 0, 1, 0, 4'd3, 1);
        rst = 1'b1; exec_done = 1'b1;
        tick(); check_outs("i7.rst", 3'd0, 0, 0, 0, 0, 0, 4'd0, 0);
        check("i7.rst.opcode", 32'(opcode), 0);
        check("i7.rst.ind", 32'(ind), 0);
        check("i7.rst.fault", 32'(fault), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
